hazard_forward_ctrl: RTL and testbench
======================================

# hazard_forward_ctrl

Parametrised hazard and forwarding controller for the 5-stage pipeline; successor to the two-operand forwarding unit. Produces independent per-source forwarding selects for the EX stage, detects load-use hazards in ID, and holds the front end for a configurable load latency. It also freezes the pipe while data memory is not ready and keeps a saturating stall-cycle counter. It sits between the ID/EX, EX/MEM and MEM/WB pipeline registers and drives PC, IF/ID and ID/EX control.

## Interface
- REG_AW, 5, register address width
- NUM_SRC, 2, source operands per instruction; all source buses are packed, source 0 in the LSBs
- LOAD_LAT, 1, load-use bubble cycles (≥1)
- FWD_EN, 1, 1 = forwarding mode; 0 = stall-only mode
- CNT_W, 16, stall counter width

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- id_rs  in  NUM_SRC*REG_AW  ID-stage source registers
- id_rs_used  in  NUM_SRC  ID-stage source actually read
- ex_rs  in  NUM_SRC*REG_AW  ID/EX source registers
- id_ex_rd, ex_mem_rd, mem_wb_rd  in  REG_AW each  destination registers
- id_ex_reg_write, ex_mem_reg_write, mem_wb_reg_write  in  1 each
- id_ex_mem_read, ex_mem_mem_read  in  1 each  load in stage
- dmem_ready  in  1  data memory completes access this cycle
- cnt_clr  in  1  synchronous clear of stall_cnt
- fwd_sel  out  2*NUM_SRC  per-source select: 00 none, 10 EX/MEM, 01 MEM/WB
- pc_write, if_id_write  out  1  0 = hold
- id_ex_flush  out  1  insert bubble into ID/EX
- ex_mem_hold  out  1  hold EX/MEM and MEM/WB
- stall_cnt  out  CNT_W  stalled-cycle count

## Operation
- Forwarding (FWD_EN=1), per source i, independent of other sources: EX/MEM match (ex_mem_reg_write, rd≠0, rd==ex_rs[i], !ex_mem_mem_read) → 10. Otherwise a MEM/WB match (mem_wb_reg_write, rd≠0, rd==ex_rs[i]) → 01. Otherwise 00. x0 is never forwarded. FWD_EN=0 → fwd_sel all 0.
- Load-use hazard (FWD_EN=1): id_ex_mem_read && id_ex_rd≠0 && there is an i with id_rs_used[i] && id_rs[i]==id_ex_rd.
- RAW hazard (FWD_EN=0): id_rs_used[i] with id_rs[i]≠0 matching a writing id_ex_rd or ex_mem_rd. This hazard is combinational and has no counter.
- Memory wait: ex_mem_mem_read && !dmem_ready.
- FSM states: RUN and LOAD_STALL; 4-bit or wider down-counter lcnt.
  - RUN + load-use → stall this cycle. If LOAD_LAT>1: go to LOAD_STALL with lcnt=LOAD_LAT-1. Otherwise stay in RUN.
  - LOAD_STALL → stall every cycle and decrement lcnt. At lcnt==1, go to RUN on the next edge.
- Stall outputs: pc_write=0, if_id_write=0, id_ex_flush=1.
- Memory wait has priority over everything. It drives pc_write=0, if_id_write=0, ex_mem_hold=1 and id_ex_flush=0. The FSM state and lcnt hold during a memory wait.
- stall_cnt increments on every cycle with pc_write=0, saturates at all-ones, and clears on cnt_clr. A clear wins over an increment in the same cycle.

## Timing
- fwd_sel, pc_write, if_id_write, id_ex_flush and ex_mem_hold are combinational from the inputs and state, with zero latency.
- A load-use hazard stalls for exactly LOAD_LAT cycles, plus any memory-wait cycles.
- Reset values: state=RUN, lcnt=0, stall_cnt=0. With idle inputs: pc_write=1, if_id_write=1, id_ex_flush=0, ex_mem_hold=0, fwd_sel=0.
- Reset asserted mid-stall returns to RUN immediately (asynchronous). The first edge after release evaluates hazards afresh.
- A new load-use hazard seen while in LOAD_STALL is not re-armed; the ID instruction is re-checked once the FSM returns to RUN.

## Structure
- Package hazard_pkg holds: FWD_NONE=2'b00, FWD_EX_MEM=2'b10, FWD_MEM_WB=2'b01, and the state enum {RUN, LOAD_STALL}.
- Sub-module fwd_select: a combinational per-source comparator, instantiated NUM_SRC times via generate.
- FSM, counters and stall-output logic live in the top level.

## Test plan
- ex_rs={x3,x2}, ex_mem_rd=x2 (writing), mem_wb_rd=x3 (writing) → fwd_sel=4'b0110. Both sources are resolved in the same cycle.
- ex_rs0=x5, ex_mem_rd=x5 and mem_wb_rd=x5, both writing → fwd_sel[1:0]=10. Repeat with rd=x0 → 00.
- LOAD_LAT=3: load to x7 in ID/EX, id_rs0=x7 used → pc_write=0 and id_ex_flush=1 for exactly 3 cycles, then 1/0. stall_cnt=3.
- Memory wait during LOAD_STALL (dmem_ready=0 for 2 cycles) → ex_mem_hold=1 and id_ex_flush=0 during the wait, lcnt frozen. Total stall = LOAD_LAT+2.
- FWD_EN=0: id_rs0=x4, ex_mem_rd=x4 writing → stall while the match persists, fwd_sel=0. id_rs_used=0 → no stall.
- rst_n pulsed low in LOAD_STALL → RUN and stall_cnt=0 immediately. stall_cnt forced to saturate → holds at 16'hFFFF. cnt_clr together with a stall → 0.

Source files
------------

// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared definitions for the hazard and forwarding controller.
// Contents:
//   FWD_NONE / FWD_EX_MEM / FWD_MEM_WB  per-source EX-stage operand selects
//   state_t                             load-use stall FSM states
package hazard_pkg;

  localparam logic [1:0] FWD_NONE   = 2'b00;
  localparam logic [1:0] FWD_EX_MEM = 2'b10;
  localparam logic [1:0] FWD_MEM_WB = 2'b01;

  typedef enum logic {
    RUN        = 1'b0,
    LOAD_STALL = 1'b1
  } state_t;

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle for hazard_forward_ctrl.
// master: the pipeline, which drives register addresses and stage flags and
//         receives the forwarding selects and hold/flush controls.
// slave : the controller.
// All per-source buses are packed, with source 0 in the LSBs.
interface hazard_forward_ctrl_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int CNT_W   = 16
);
  logic [NUM_SRC*REG_AW-1:0] id_rs;
  logic [NUM_SRC-1:0]        id_rs_used;
  logic [NUM_SRC*REG_AW-1:0] ex_rs;
  logic [REG_AW-1:0]         id_ex_rd;
  logic [REG_AW-1:0]         ex_mem_rd;
  logic [REG_AW-1:0]         mem_wb_rd;
  logic                      id_ex_reg_write;
  logic                      ex_mem_reg_write;
  logic                      mem_wb_reg_write;
  logic                      id_ex_mem_read;
  logic                      ex_mem_mem_read;
  logic                      dmem_ready;
  logic                      cnt_clr;
  logic [2*NUM_SRC-1:0]      fwd_sel;
  logic                      pc_write;
  logic                      if_id_write;
  logic                      id_ex_flush;
  logic                      ex_mem_hold;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output id_rs, id_rs_used, ex_rs, id_ex_rd, ex_mem_rd, mem_wb_rd,
           id_ex_reg_write, ex_mem_reg_write, mem_wb_reg_write,
           id_ex_mem_read, ex_mem_mem_read, dmem_ready, cnt_clr,
    input  fwd_sel, pc_write, if_id_write, id_ex_flush, ex_mem_hold, stall_cnt
  );

  modport slave (
    input  id_rs, id_rs_used, ex_rs, id_ex_rd, ex_mem_rd, mem_wb_rd,
           id_ex_reg_write, ex_mem_reg_write, mem_wb_reg_write,
           id_ex_mem_read, ex_mem_mem_read, dmem_ready, cnt_clr,
    output fwd_sel, pc_write, if_id_write, id_ex_flush, ex_mem_hold, stall_cnt
  );
endinterface

// File: rtl/hazard_forward_ctrl_fwd_select.sv
// Forwarding select for one EX-stage source operand.
// Ports:
//   i_ex_rs                 source register held in ID/EX
//   i_ex_mem_rd / i_mem_wb_rd  destination registers of the later stages
//   i_*_reg_write, i_ex_mem_mem_read  stage qualifiers
//   o_sel                   FWD_NONE / FWD_EX_MEM / FWD_MEM_WB
// A load in EX/MEM has no data yet, so it is skipped and the older MEM/WB
// value is considered instead.
module fwd_select
  import hazard_pkg::*;
#(
  parameter int REG_AW = 5,
  parameter bit FWD_EN = 1'b1
) (
  input  logic [REG_AW-1:0] i_ex_rs,
  input  logic [REG_AW-1:0] i_ex_mem_rd,
  input  logic [REG_AW-1:0] i_mem_wb_rd,
  input  logic              i_ex_mem_reg_write,
  input  logic              i_ex_mem_mem_read,
  input  logic              i_mem_wb_reg_write,
  output logic [1:0]        o_sel
);
  logic w_ex_mem_hit;
  logic w_mem_wb_hit;

  assign w_ex_mem_hit = i_ex_mem_reg_write && (i_ex_mem_rd != '0) &&
                        (i_ex_mem_rd == i_ex_rs) && !i_ex_mem_mem_read;
  assign w_mem_wb_hit = i_mem_wb_reg_write && (i_mem_wb_rd != '0) &&
                        (i_mem_wb_rd == i_ex_rs);

  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    o_sel = FWD_NONE;
    if (FWD_EN) begin
      if (w_ex_mem_hit)      o_sel = FWD_EX_MEM;
      else if (w_mem_wb_hit) o_sel = FWD_MEM_WB;
    end
  end
endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller for the 5-stage pipeline.
// Ports:
//   clk, rst_n  clock (rising edge) and asynchronous active-low reset
//   bus         hazard_forward_ctrl_if.slave: stage registers/flags in,
//               fwd_sel, pc_write, if_id_write, id_ex_flush, ex_mem_hold,
//               stall_cnt out
// FWD_EN=1 forwards and stalls only on load-use for LOAD_LAT cycles;
// FWD_EN=0 stalls on any RAW against ID/EX or EX/MEM. A data-memory wait
// freezes the back end and overrides every other stall.
module hazard_forward_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_AW   = 5,
  parameter int NUM_SRC  = 2,
  parameter int LOAD_LAT = 1,
  parameter bit FWD_EN   = 1'b1,
  parameter int CNT_W    = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  hazard_forward_ctrl_if.slave bus
);
  localparam int LCNT_W = ($clog2(LOAD_LAT + 1) > 4) ? $clog2(LOAD_LAT + 1) : 4;

  state_t              r_state, w_state_nxt;
  logic [LCNT_W-1:0]   r_lcnt, w_lcnt_nxt;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [2*NUM_SRC-1:0] w_fwd_sel;
  logic w_load_use, w_raw, w_mem_wait, w_stall;
  logic w_pc_write, w_if_id_write, w_id_ex_flush, w_ex_mem_hold;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_fwd
    fwd_select #(.REG_AW(REG_AW), .FWD_EN(FWD_EN)) u_fwd_select (
      .i_ex_rs            (bus.ex_rs[g*REG_AW +: REG_AW]),
      .i_ex_mem_rd        (bus.ex_mem_rd),
      .i_mem_wb_rd        (bus.mem_wb_rd),
      .i_ex_mem_reg_write (bus.ex_mem_reg_write),
      .i_ex_mem_mem_read  (bus.ex_mem_mem_read),
      .i_mem_wb_reg_write (bus.mem_wb_reg_write),
      .o_sel              (w_fwd_sel[2*g +: 2])
    );
  end

  // ID-stage hazard detection: load-use in forwarding mode, plain RAW
  // against both in-flight writers in stall-only mode.
  always_comb begin
    w_load_use = 1'b0;
    w_raw      = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.id_rs_used[i] && (bus.id_rs[i*REG_AW +: REG_AW] == bus.id_ex_rd))
        w_load_use = 1'b1;
      if (bus.id_rs_used[i] && (bus.id_rs[i*REG_AW +: REG_AW] != '0) &&
          ((bus.id_ex_reg_write  && (bus.id_rs[i*REG_AW +: REG_AW] == bus.id_ex_rd)) ||
           (bus.ex_mem_reg_write && (bus.id_rs[i*REG_AW +: REG_AW] == bus.ex_mem_rd))))
        w_raw = 1'b1;
    end
    w_load_use = w_load_use && FWD_EN && bus.id_ex_mem_read && (bus.id_ex_rd != '0);
    w_raw      = w_raw && !FWD_EN;
  end

  assign w_mem_wait = bus.ex_mem_mem_read && !bus.dmem_ready;

  // Next state and stall decision. A memory wait freezes state and lcnt.
  // A load-use seen while already in LOAD_STALL is ignored here; the ID
  // instruction is re-checked after the return to RUN.
  always_comb begin
    w_state_nxt = r_state;
    w_lcnt_nxt  = r_lcnt;
    w_stall     = 1'b0;
    if (!w_mem_wait) begin
      case (r_state)
        RUN: begin
          if (w_load_use) begin
            w_stall = 1'b1;
            if (LOAD_LAT > 1) begin
              w_state_nxt = LOAD_STALL;
              w_lcnt_nxt  = LCNT_W'(LOAD_LAT - 1);
            end
          end else if (w_raw) begin
            w_stall = 1'b1;
          end
        end
        LOAD_STALL: begin
          w_stall    = 1'b1;
          w_lcnt_nxt = r_lcnt - LCNT_W'(1);
          if (r_lcnt == LCNT_W'(1)) w_state_nxt = RUN;
        end
        default: w_state_nxt = RUN;
      endcase
    end
  end

  always_comb begin
    w_pc_write    = 1'b1;
    w_if_id_write = 1'b1;
    w_id_ex_flush = 1'b0;
    w_ex_mem_hold = 1'b0;
    if (w_mem_wait) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_ex_mem_hold = 1'b1;
    end else if (w_stall) begin
      w_pc_write    = 1'b0;
      w_if_id_write = 1'b0;
      w_id_ex_flush = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RUN;
      r_lcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_lcnt  <= w_lcnt_nxt;
    end
  end

  // Saturating stalled-cycle counter; a clear beats an increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                  r_stall_cnt <= '0;
    else if (bus.cnt_clr)                        r_stall_cnt <= '0;
    else if (!w_pc_write && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
  end

  assign bus.fwd_sel     = w_fwd_sel;
  assign bus.pc_write    = w_pc_write;
  assign bus.if_id_write = w_if_id_write;
  assign bus.id_ex_flush = w_id_ex_flush;
  assign bus.ex_mem_hold = w_ex_mem_hold;
  assign bus.stall_cnt   = r_stall_cnt;
endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Testbench for hazard_forward_ctrl.
// dut_a: forwarding mode, LOAD_LAT=3, 16-bit counter.
// dut_b: stall-only mode, LOAD_LAT=1, 8-bit counter so saturation is reached
//        in a few hundred cycles.
// Stimulus pushes the expected outputs into a queue; a monitor on the
// falling edge pops and compares.
module tb_hazard_forward_ctrl;

  typedef struct packed {
    logic        dut;
    logic [3:0]  fwd;
    logic        pc;
    logic        ifid;
    logic        flush;
    logic        hold;
    logic [15:0] cnt;
  } exp_t;

  logic clk;
  logic rst_n;

  exp_t  exp_q[$];
  string name_q[$];
  int    n_checks = 0;
  int    n_errors = 0;

  hazard_forward_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(16)) a_if ();
  hazard_forward_ctrl_if #(.REG_AW(5), .NUM_SRC(2), .CNT_W(8))  b_if ();

  hazard_forward_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(3), .FWD_EN(1'b1), .CNT_W(16))
    dut_a (.clk(clk), .rst_n(rst_n), .bus(a_if));
  hazard_forward_ctrl #(.REG_AW(5), .NUM_SRC(2), .LOAD_LAT(1), .FWD_EN(1'b0), .CNT_W(8))
    dut_b (.clk(clk), .rst_n(rst_n), .bus(b_if));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor
  exp_t        m_exp;
  string       m_name;
  logic [23:0] m_act;
  logic [23:0] m_req;

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      m_exp  = exp_q.pop_front();
      m_name = name_q.pop_front();
      if (m_exp.dut == 1'b0)
        m_act = {a_if.fwd_sel, a_if.pc_write, a_if.if_id_write,
                 a_if.id_ex_flush, a_if.ex_mem_hold, a_if.stall_cnt};
      else
        m_act = {b_if.fwd_sel, b_if.pc_write, b_if.if_id_write,
                 b_if.id_ex_flush, b_if.ex_mem_hold, 8'h00, b_if.stall_cnt};
      m_req = {m_exp.fwd, m_exp.pc, m_exp.ifid, m_exp.flush, m_exp.hold, m_exp.cnt};
      n_checks++;
      if (m_act !== m_req) begin
        n_errors++;
        $display("FAIL %s: got fwd=%b pc=%b ifid=%b flush=%b hold=%b cnt=%h, expected fwd=%b pc=%b ifid=%b flush=%b hold=%b cnt=%h",
                 m_name, m_act[23:20], m_act[19], m_act[18], m_act[17], m_act[16], m_act[15:0],
                 m_req[23:20], m_req[19], m_req[18], m_req[17], m_req[16], m_req[15:0]);
      end
    end
  end

  task automatic expect_out(input logic d, input string nm, input logic [3:0] f,
                            input logic pc, input logic ifid, input logic fl,
                            input logic hd, input logic [15:0] c);
    exp_t e;
    e.dut = d; e.fwd = f; e.pc = pc; e.ifid = ifid; e.flush = fl; e.hold = hd; e.cnt = c;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_a();
    a_if.id_rs = '0; a_if.id_rs_used = '0; a_if.ex_rs = '0;
    a_if.id_ex_rd = '0; a_if.ex_mem_rd = '0; a_if.mem_wb_rd = '0;
    a_if.id_ex_reg_write = 1'b0; a_if.ex_mem_reg_write = 1'b0; a_if.mem_wb_reg_write = 1'b0;
    a_if.id_ex_mem_read = 1'b0; a_if.ex_mem_mem_read = 1'b0;
    a_if.dmem_ready = 1'b1; a_if.cnt_clr = 1'b0;
  endtask

  task automatic idle_b();
    b_if.id_rs = '0; b_if.id_rs_used = '0; b_if.ex_rs = '0;
    b_if.id_ex_rd = '0; b_if.ex_mem_rd = '0; b_if.mem_wb_rd = '0;
    b_if.id_ex_reg_write = 1'b0; b_if.ex_mem_reg_write = 1'b0; b_if.mem_wb_reg_write = 1'b0;
    b_if.id_ex_mem_read = 1'b0; b_if.ex_mem_mem_read = 1'b0;
    b_if.dmem_ready = 1'b1; b_if.cnt_clr = 1'b0;
  endtask

  // Place a load to x7 in ID/EX with ID source 0 reading x7.
  task automatic load_use_a();
    a_if.id_ex_mem_read = 1'b1; a_if.id_ex_reg_write = 1'b1; a_if.id_ex_rd = 5'd7;
    a_if.id_rs = {5'd0, 5'd7}; a_if.id_rs_used = 2'b01;
  endtask

  // The flushed load leaves ID/EX; the bubble carries no load.
  task automatic clear_idex_a();
    a_if.id_ex_mem_read = 1'b0; a_if.id_ex_reg_write = 1'b0; a_if.id_ex_rd = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle_a();
    idle_b();
    expect_out(1'b0, "a_reset", 4'b0000, 1, 1, 0, 0, 16'd0);
    expect_out(1'b1, "b_reset", 4'b0000, 1, 1, 0, 0, 16'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // ---------------- forwarding (dut_a) ----------------
    a_if.ex_rs = {5'd3, 5'd2};
    a_if.ex_mem_rd = 5'd2; a_if.ex_mem_reg_write = 1'b1;
    a_if.mem_wb_rd = 5'd3; a_if.mem_wb_reg_write = 1'b1;
    expect_out(1'b0, "fwd_two_src", 4'b0110, 1, 1, 0, 0, 16'd0);
    tick();

    a_if.ex_rs = {5'd0, 5'd5}; a_if.ex_mem_rd = 5'd5; a_if.mem_wb_rd = 5'd5;
    expect_out(1'b0, "fwd_exmem_prio", 4'b0010, 1, 1, 0, 0, 16'd0);
    tick();

    a_if.ex_rs = {5'd0, 5'd0}; a_if.ex_mem_rd = 5'd0; a_if.mem_wb_rd = 5'd0;
    expect_out(1'b0, "fwd_x0", 4'b0000, 1, 1, 0, 0, 16'd0);
    tick();

    a_if.ex_rs = {5'd6, 5'd6}; a_if.ex_mem_rd = 5'd6; a_if.mem_wb_rd = 5'd6;
    a_if.ex_mem_mem_read = 1'b1;
    expect_out(1'b0, "fwd_load_skip", 4'b0101, 1, 1, 0, 0, 16'd0);
    tick();

    a_if.ex_mem_mem_read = 1'b0; a_if.ex_mem_reg_write = 1'b0; a_if.mem_wb_reg_write = 1'b0;
    expect_out(1'b0, "fwd_no_write", 4'b0000, 1, 1, 0, 0, 16'd0);
    tick();

    // ---------------- load-use, LOAD_LAT=3 ----------------
    idle_a();
    load_use_a();
    expect_out(1'b0, "lu_c0", 4'b0000, 0, 0, 1, 0, 16'd0);
    tick();
    clear_idex_a();
    expect_out(1'b0, "lu_c1", 4'b0000, 0, 0, 1, 0, 16'd1);
    tick();
    expect_out(1'b0, "lu_c2", 4'b0000, 0, 0, 1, 0, 16'd2);
    tick();
    expect_out(1'b0, "lu_done", 4'b0000, 1, 1, 0, 0, 16'd3);
    tick();

    // ---------------- memory wait inside LOAD_STALL ----------------
    load_use_a();
    expect_out(1'b0, "mw_c0", 4'b0000, 0, 0, 1, 0, 16'd3);
    tick();
    clear_idex_a();
    expect_out(1'b0, "mw_c1", 4'b0000, 0, 0, 1, 0, 16'd4);
    tick();
    a_if.ex_mem_mem_read = 1'b1; a_if.dmem_ready = 1'b0;
    expect_out(1'b0, "mw_wait0", 4'b0000, 0, 0, 0, 1, 16'd5);
    tick();
    expect_out(1'b0, "mw_wait1", 4'b0000, 0, 0, 0, 1, 16'd6);
    tick();
    a_if.ex_mem_mem_read = 1'b0; a_if.dmem_ready = 1'b1;
    expect_out(1'b0, "mw_resume", 4'b0000, 0, 0, 1, 0, 16'd7);
    tick();
    expect_out(1'b0, "mw_done", 4'b0000, 1, 1, 0, 0, 16'd8);
    tick();

    // ---------------- asynchronous reset mid-stall ----------------
    load_use_a();
    expect_out(1'b0, "rst_c0", 4'b0000, 0, 0, 1, 0, 16'd8);
    tick();
    clear_idex_a();
    expect_out(1'b0, "rst_c1", 4'b0000, 0, 0, 1, 0, 16'd9);
    tick();
    rst_n = 1'b0;
    expect_out(1'b0, "rst_async", 4'b0000, 1, 1, 0, 0, 16'd0);
    tick();
    rst_n = 1'b1;
    expect_out(1'b0, "rst_after", 4'b0000, 1, 1, 0, 0, 16'd0);
    tick();

    // ---------------- clear wins over increment ----------------
    load_use_a();
    expect_out(1'b0, "clr_c0", 4'b0000, 0, 0, 1, 0, 16'd0);
    tick();
    clear_idex_a();
    a_if.cnt_clr = 1'b1;
    expect_out(1'b0, "clr_c1", 4'b0000, 0, 0, 1, 0, 16'd1);
    tick();
    a_if.cnt_clr = 1'b0;
    expect_out(1'b0, "clr_c2", 4'b0000, 0, 0, 1, 0, 16'd0);
    tick();
    expect_out(1'b0, "clr_done", 4'b0000, 1, 1, 0, 0, 16'd1);
    tick();

    // ---------------- stall-only mode (dut_b) ----------------
    idle_a();
    b_if.id_rs = {5'd0, 5'd4}; b_if.id_rs_used = 2'b01;
    b_if.ex_rs = {5'd0, 5'd4};
    b_if.ex_mem_rd = 5'd4; b_if.ex_mem_reg_write = 1'b1;
    expect_out(1'b1, "raw_exmem0", 4'b0000, 0, 0, 1, 0, 16'd0);
    tick();
    expect_out(1'b1, "raw_exmem1", 4'b0000, 0, 0, 1, 0, 16'd1);
    tick();
    b_if.id_rs_used = 2'b00;
    expect_out(1'b1, "raw_unused", 4'b0000, 1, 1, 0, 0, 16'd2);
    tick();
    idle_b();
    b_if.id_rs = {5'd9, 5'd0}; b_if.id_rs_used = 2'b10;
    b_if.id_ex_rd = 5'd9; b_if.id_ex_reg_write = 1'b1;
    expect_out(1'b1, "raw_idex_src1", 4'b0000, 0, 0, 1, 0, 16'd2);
    tick();
    b_if.id_rs = {5'd0, 5'd0}; b_if.id_ex_rd = 5'd0;
    expect_out(1'b1, "raw_x0", 4'b0000, 1, 1, 0, 0, 16'd3);
    tick();

    // Saturation: hold a RAW stall long past the counter range.
    b_if.id_rs = {5'd9, 5'd0}; b_if.id_ex_rd = 5'd9;
    repeat (300) tick();
    expect_out(1'b1, "sat_hold0", 4'b0000, 0, 0, 1, 0, 16'h00FF);
    tick();
    expect_out(1'b1, "sat_hold1", 4'b0000, 0, 0, 1, 0, 16'h00FF);
    tick();
    b_if.cnt_clr = 1'b1;
    expect_out(1'b1, "sat_clr", 4'b0000, 0, 0, 1, 0, 16'h00FF);
    tick();
    b_if.cnt_clr = 1'b0;
    expect_out(1'b1, "sat_after_clr", 4'b0000, 0, 0, 1, 0, 16'd0);
    tick();
    expect_out(1'b1, "sat_recount", 4'b0000, 0, 0, 1, 0, 16'd1);
    tick();

    @(negedge clk);
    #1;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
